wb_rr_arbiter: RTL

- Round-robin arbiter sharing one Wishbone B4 pipelined slave (the SoC single-port RAM) between N masters.
- Typical masters: Ibex instruction port, Ibex data port, and the debug module's system-bus port.
- Sits between the masters and the RAM in the SoC top.
- Grants whole bus cycles (CYC-based locking); never interleaves beats from different masters.

---
 rtl/wb_rr_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin arbiter sharing one Wishbone B4 pipelined slave among N masters
// Optional bus-hang timeout is built in when WB_ARB_TIMEOUT_EN is defined.
module wb_rr_arbiter #(
   parameter int N       = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int OW      = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      m_cyc,
   input  logic [N-1:0]      m_stb,
   input  logic [N-1:0]      m_we,
   input  logic [N*AW-1:0]   m_adr,
   input  logic [N*DW-1:0]   m_dat_w,
   input  logic [N*DW/8-1:0] m_sel,
   output logic [DW-1:0]     m_dat_r,
   output logic [N-1:0]      m_ack,
   output logic [N-1:0]      m_err,
   output logic [N-1:0]      m_stall,
   output logic              s_cyc,
   output logic              s_stb,
   output logic              s_we,
   output logic [AW-1:0]     s_adr,
   output logic [DW-1:0]     s_dat_w,
   output logic [DW/8-1:0]   s_sel,
   input  logic [DW-1:0]     s_dat_r,
   input  logic              s_ack,
   input  logic              s_err,
   input  logic              s_stall,
   output logic [N-1:0]      grant
);
   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = DW / 8;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_next;
   logic [LW-1:0] last, last_next;
   logic [N-1:0]  grant_next;
   logic [OW-1:0] outstanding, outstanding_next;
   logic          found;
   logic [LW-1:0] winner;
   logic [N-1:0]  winner_oh;
   logic          owner_cyc, owner_stb, at_limit, accept, resp, timeout_hit;

   // grant is the one-hot owner, so it doubles as the owner select everywhere
   assign owner_cyc = |(m_cyc & grant);
   assign owner_stb = |(m_stb & grant);
   assign at_limit  = &outstanding;
   assign accept    = s_stb & ~s_stall;
   assign resp      = s_ack | s_err;
   assign m_dat_r   = s_dat_r;

   // first requester after the previous owner, wrapping modulo N
   always_comb begin
      found     = 1'b0;
      winner    = last;
      winner_oh = '0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && m_cyc[i] && ((int'(last) + k) % N) == i) begin
               found        = 1'b1;
               winner       = LW'(i);
               winner_oh[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      s_we    = 1'b0;
      s_adr   = '0;
      s_dat_w = '0;
      s_sel   = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            s_we    = m_we[i];
            s_adr   = m_adr[i*AW +: AW];
            s_dat_w = m_dat_w[i*DW +: DW];
            s_sel   = m_sel[i*SW +: SW];
         end
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;

   always_ff @(posedge clk) begin
      if (rst || state != BUSY || outstanding == '0 || accept || resp)
         tcnt <= '0;
      else
         tcnt <= tcnt + 1'b1;
   end

   assign timeout_hit = (state == BUSY) && owner_cyc && (outstanding != '0) &&
                        (tcnt == TW'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         last        <= LW'(N - 1);
         outstanding <= '0;
      end else begin
         state       <= state_next;
         grant       <= grant_next;
         last        <= last_next;
         outstanding <= outstanding_next;
      end
   end

   always_comb begin
      state_next       = state;
      grant_next       = grant;
      last_next        = last;
      outstanding_next = outstanding;
      case (state)
         IDLE: begin
            outstanding_next = '0;
            if (found) begin
               state_next = BUSY;
               grant_next = winner_oh;
               last_next  = winner;
            end
         end
         BUSY: begin
            // dropping CYC (or a timeout) abandons any beats still in flight
            if (!owner_cyc || timeout_hit) begin
               state_next       = IDLE;
               grant_next       = '0;
               outstanding_next = '0;
            end else if (accept && !resp) begin
               outstanding_next = outstanding + 1'b1;
            end else if (resp && !accept && outstanding != '0) begin
               outstanding_next = outstanding - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      m_ack   = '0;
      m_err   = '0;
      m_stall = '1;
      if (!rst && state == BUSY) begin
         if (timeout_hit) begin
            m_err = grant;
         end else begin
            s_cyc   = owner_cyc;
            s_stb   = owner_cyc & owner_stb & ~at_limit;
            m_stall = ~grant | {N{s_stall | at_limit}};
            m_ack   = grant & {N{owner_cyc & s_ack}};
            m_err   = grant & {N{owner_cyc & s_err}};
         end
      end
   end
endmodule
